// File: rtl/crc_tx_arbiter_pkg.sv
// Shared types and constants for the CRC-32 dibit-stream transmit arbiter.
package crc_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, XFER, HOLD} arb_state_e;

  // The appender emits a 32-bit CRC as 16 dibits after the last data dibit.
  localparam int unsigned CRC_TAIL_DIBITS = 16;
  localparam int unsigned MIN_HOLDOFF     = CRC_TAIL_DIBITS;

endpackage

// File: rtl/crc_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr_i+1, wrapping.
module rr_pick #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [ID_W-1:0] winner_o,
  output logic            any_o
);

  int unsigned idx;

  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    idx      = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = 32'(ptr_i) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_o && req_i[idx[ID_W-1:0]]) begin
        winner_o = idx[ID_W-1:0];
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/crc_tx_arbiter.sv
// Round-robin arbiter sharing one CRC-32 dibit appender between NREQ frame sources, with a
// post-eop hold-off. Optional frame-length watchdog enabled by defining CRC_ARB_WDOG_EN.
module crc_tx_arbiter
  import crc_arb_pkg::*;
#(
  parameter  int unsigned NREQ       = 4,
  parameter  int unsigned HOLDOFF    = 16,
  parameter  int unsigned MAX_DIBITS = 6072,
  localparam int unsigned ID_W       = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  input  logic [NREQ*2-1:0] in_d,
  input  logic [NREQ-1:0]   in_sop,
  input  logic [NREQ-1:0]   in_eop,
  output logic [1:0]        crc_d,
  output logic              crc_sop,
  output logic              crc_eop,
  output logic [ID_W-1:0]   src_id,
  output logic              busy,
  output logic              wdog_err
);

  localparam int unsigned         CNT_W    = $clog2(HOLDOFF + 1);
  localparam logic [CNT_W-1:0]    HoldInit = CNT_W'(HOLDOFF - 1);

  if (NREQ < 2) begin : g_chk_nreq
    $error("crc_tx_arbiter: NREQ must be at least 2");
  end
  if (HOLDOFF < MIN_HOLDOFF) begin : g_chk_holdoff
    $error("crc_tx_arbiter: HOLDOFF shorter than the CRC tail");
  end
  if (MAX_DIBITS < 1 || MAX_DIBITS > 8191) begin : g_chk_max_dibits
    $error("crc_tx_arbiter: MAX_DIBITS must fit the 13-bit dibit counter");
  end

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  src_id_q, src_id_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       crc_d_q, crc_d_d;
  logic             crc_sop_q, crc_sop_d;
  logic             crc_eop_q, crc_eop_d;
  logic             fwd;
  logic             wdog_hit;

  logic [ID_W-1:0]  pick_id;
  logic             pick_any;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (pick_id),
    .any_o    (pick_any)
  );

  // Only the granted source is ever looked at.
  logic [1:0] sel_d;
  logic       sel_sop, sel_eop, sel_req;

  assign sel_d   = in_d[{src_id_q, 1'b0} +: 2];
  assign sel_sop = in_sop[src_id_q];
  assign sel_eop = in_eop[src_id_q];
  assign sel_req = req[src_id_q];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    src_id_d  = src_id_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    crc_d_d   = crc_d_q;
    crc_sop_d = 1'b0;
    crc_eop_d = 1'b0;
    fwd       = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          ptr_d          = pick_id;
          src_id_d       = pick_id;
          gnt_d          = '0;
          gnt_d[pick_id] = 1'b1;
          busy_d         = 1'b1;
          state_d        = GRANT;
        end
      end
      GRANT: begin
        if (sel_sop) begin
          fwd       = 1'b1;
          crc_sop_d = 1'b1;
        end else if (!sel_req) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      XFER: fwd = 1'b1;
      HOLD: begin
        if (cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A watchdog abort closes the frame exactly like a real eop.
    if (fwd) begin
      crc_d_d   = sel_d;
      crc_eop_d = sel_eop | wdog_hit;
      if (crc_eop_d) begin
        gnt_d   = '0;
        cnt_d   = HoldInit;
        state_d = HOLD;
      end else begin
        state_d = XFER;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= ID_W'(NREQ - 1);
      src_id_q  <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      crc_d_q   <= 2'b00;
      crc_sop_q <= 1'b0;
      crc_eop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      src_id_q  <= src_id_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      crc_d_q   <= crc_d_d;
      crc_sop_q <= crc_sop_d;
      crc_eop_q <= crc_eop_d;
    end
  end

`ifdef CRC_ARB_WDOG_EN
  localparam logic [12:0] WdogLast = 13'(MAX_DIBITS - 1);

  logic [12:0] dcnt_q, dcnt_d;
  logic        wdog_err_q, wdog_err_d;

  // Fires on the MAX_DIBITS-th forwarded dibit; dcnt_q counts dibits already forwarded.
  assign wdog_hit = (dcnt_q == WdogLast);

  always_comb begin
    dcnt_d     = dcnt_q;
    wdog_err_d = fwd & wdog_hit & ~sel_eop;
    if (state_q == IDLE) begin
      dcnt_d = '0;
    end else if (fwd) begin
      dcnt_d = dcnt_q + 13'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dcnt_q     <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      dcnt_q     <= dcnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_hit = 1'b0;
  assign wdog_err = 1'b0;
`endif

  assign gnt     = gnt_q;
  assign crc_d   = crc_d_q;
  assign crc_sop = crc_sop_q;
  assign crc_eop = crc_eop_q;
  assign src_id  = src_id_q;
  assign busy    = busy_q;

endmodule
